// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/unified_mem_arbiter_wait_counter.sv
// Memory wait-state down-counter: loaded at grant, done once it reaches zero.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and data (D) requesters.
// Define UNIFIED_MEM_ARB_RR_EN for round-robin on contention (default: D wins).
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant_d
);

  arb_state_e state;
  logic       any_req;
  logic       win_d;
  logic       cnt_done;

  assign any_req = i_req | d_req;

`ifdef UNIFIED_MEM_ARB_RR_EN
  // Last-winner flag; starts at I so D takes the first tie.
  logic last_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                           last_d <= REQ_I;
    else if (state == IDLE && any_req)  last_d <= win_d;
  end

  assign win_d = d_req & (~i_req | (last_d == REQ_I));
`else
  assign win_d = d_req;
`endif

  mem_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .CLK      (CLK),
    .RST      (RST),
    .load     (state == IDLE && any_req),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      grant_d <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          state   <= ACCESS;
          m_en    <= 1'b1;
          m_we    <= win_d & d_we;
          m_addr  <= win_d ? d_addr : i_addr;
          m_wdata <= win_d ? d_wdata : '0;
          grant_d <= win_d;
        end
        ACCESS: if (cnt_done) begin
          // m_we still reflects the access being retired on this edge.
          if (!m_we) begin
            if (grant_d) d_rdata <= m_rdata;
            else         i_rdata <= m_rdata;
          end
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          d_ack <= grant_d;
          i_ack <= ~grant_d;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: drivers push expected read data
// per port, a negedge monitor checks grants, latency, bus stability and data.
module tb_unified_mem_arbiter;
  localparam int AW = 32, DW = 32, W = 2, CW = 4;

  logic CLK = 1'b0, RST = 1'b0;
  logic i_req, d_req, d_we, i_ack, d_ack, m_en, m_we, busy, grant_d;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    total++; bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Memory model: I region = computed ROM, D region (addr bit 8) = 16-word RAM.
  function automatic logic [31:0] irom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  logic [31:0] dmem [16];
  logic        init_mem;
  int          en_cnt;

  always @(posedge CLK) begin
    if (init_mem) for (int k = 0; k < 16; k++) dmem[k] <= 32'h1000 + k;
    else if (m_en && m_we) dmem[m_addr[5:2]] <= m_wdata;
  end

  always @(posedge CLK or negedge RST)
    if (!RST) en_cnt <= 0;
    else      en_cnt <= m_en ? en_cnt + 1 : 0;

  // Read data only becomes valid after W cycles of m_en.
  always_comb begin
    m_rdata = 32'hBAD0_BAD0;
    if (m_en && en_cnt >= W) m_rdata = m_addr[8] ? dmem[m_addr[5:2]] : irom(m_addr);
  end

  // Scoreboard queues and requester-side reference state.
  logic [31:0] exp_i[$], exp_d[$];
  logic [31:0] dmodel [16];
  logic [31:0] d_rd_model;

  // Monitor
  logic p_ireq, p_dreq, p_dwe, p_men, p_iack, p_dack, last_d, exp_gd, g_we;
  logic [31:0] p_iaddr, p_daddr, p_dwdata, g_addr, g_wdata, cur_i, cur_d, e;
  int rise_cyc;

  always @(negedge CLK) begin
    if (!RST) begin
      last_d = 1'b0; p_men = 1'b0; p_iack = 1'b0; p_dack = 1'b0;
      cur_i = '0; cur_d = '0;
    end else begin
      if (m_en && !p_men) begin
`ifdef UNIFIED_MEM_ARB_RR_EN
        exp_gd = (p_ireq && p_dreq) ? ~last_d : p_dreq;
`else
        exp_gd = p_dreq;
`endif
        chk("grant_d", grant_d, exp_gd);
        last_d = exp_gd;
        rise_cyc = cyc;
        g_addr = exp_gd ? p_daddr : p_iaddr;
        g_we = exp_gd & p_dwe;
        g_wdata = p_dwdata;
      end
      if (m_en) begin
        chk("m_addr", m_addr, g_addr);
        chk("m_we", m_we, g_we);
        if (g_we) chk("m_wdata", m_wdata, g_wdata);
      end
      if (i_ack) begin
        chk("i_ack_latency", cyc - rise_cyc, W + 1);
        chk("i_ack_width", p_iack, 1'b0);
        chk("ack_exclusive", d_ack, 1'b0);
        chk("d_rdata_hold", d_rdata, cur_d);
        if (exp_i.size() == 0) flag("i_ack_unexpected");
        else begin e = exp_i.pop_front(); chk("i_rdata", i_rdata, e); cur_i = e; end
      end
      if (d_ack) begin
        chk("d_ack_latency", cyc - rise_cyc, W + 1);
        chk("d_ack_width", p_dack, 1'b0);
        chk("i_rdata_hold", i_rdata, cur_i);
        if (exp_d.size() == 0) flag("d_ack_unexpected");
        else begin e = exp_d.pop_front(); chk("d_rdata", d_rdata, e); cur_d = e; end
      end
      p_men = m_en; p_iack = i_ack; p_dack = d_ack;
    end
    p_ireq = i_req; p_dreq = d_req; p_dwe = d_we;
    p_iaddr = i_addr; p_daddr = d_addr; p_dwdata = d_wdata;
  end

  // Drivers
  task automatic i_issue(input int idx);
    i_req = 1'b1; i_addr = 32'(idx * 4);
    exp_i.push_back(irom(32'(idx * 4)));
  endtask

  task automatic d_issue(input logic we, input int idx, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = 32'h100 + 32'(idx * 4); d_wdata = wd;
    if (we) dmodel[idx] = wd;
    else    d_rd_model = dmodel[idx];
    exp_d.push_back(d_rd_model);
  endtask

  // Waits for the port's ack, then drops req in the following cycle.
  task automatic wait_ack(input logic port_d, output int ack_cyc);
    logic seen;
    seen = 1'b0; ack_cyc = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLK);
      if (port_d ? d_ack : i_ack) begin seen = 1'b1; ack_cyc = cyc; end
    end
    if (!seen) flag(port_d ? "d_ack_timeout" : "i_ack_timeout");
    @(posedge CLK); #1;
    if (port_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic drive_i(input int n);
    int c;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1 i_issue($urandom_range(0, 15));
      wait_ack(1'b0, c);
    end
  endtask

  task automatic drive_d(input int n);
    int c;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1 d_issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      wait_ack(1'b1, c);
    end
  endtask

  initial begin
    int c0, c1, c2;
    logic si, sd;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    init_mem = 1'b1;
    for (int k = 0; k < 16; k++) dmodel[k] = 32'h1000 + k;
    d_rd_model = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_m_en", m_en, 0);       chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);   chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);     chk("rst_busy", busy, 0);
    chk("rst_grant_d", grant_d, 0); chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    init_mem = 1'b0; RST = 1'b1;

    // Reset during the second ACCESS cycle: access dropped, no ack.
    @(posedge CLK); #1 i_req = 1'b1; i_addr = 32'h4;
    for (int k = 0; k < 20 && !m_en; k++) @(negedge CLK);
    chk("midrst_granted", m_en, 1);
    @(posedge CLK); #2 RST = 1'b0;
    #1 chk("midrst_m_en", m_en, 0); chk("midrst_busy", busy, 0);
    i_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (W + 5) @(posedge CLK);
    chk("midrst_no_ack_rdata", i_rdata, 0);

    // Single fetch, then data write and read-back.
    #1 i_issue(1); wait_ack(1'b0, c0);
    d_issue(1'b1, 4, 32'hDEAD_BEEF); wait_ack(1'b1, c0);
    d_issue(1'b0, 4, 32'h0);         wait_ack(1'b1, c0);

    // Contention rounds.
    for (int r = 0; r < 4; r++) begin
      i_issue(r + 2);
      d_issue(1'($urandom_range(0, 1)), r + 5, $urandom);
      si = 0; sd = 0;
      for (int k = 0; k < 100 && !(si && sd); k++) begin
        @(negedge CLK);
        if (i_ack) si = 1'b1;
        if (d_ack) sd = 1'b1;
        @(posedge CLK); #1;
        if (si) i_req = 1'b0;
        if (sd) d_req = 1'b0;
      end
      if (!(si && sd)) flag("contention_timeout");
      i_req = 1'b0; d_req = 1'b0;
    end

    // Fetches with req held continuously: acks exactly W+3 apart.
    i_issue(7);  wait_ack(1'b0, c0);
    i_issue(8);  wait_ack(1'b0, c1);
    i_issue(9);  wait_ack(1'b0, c2);
    chk("b2b_spacing_1", c1 - c0, W + 3);
    chk("b2b_spacing_2", c2 - c1, W + 3);

    // Randomized concurrent traffic.
    fork
      drive_i(40);
      drive_d(40);
    join
    repeat (W + 6) @(posedge CLK);
    chk("i_queue_drained", exp_i.size(), 0);
    chk("d_queue_drained", exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    flag("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (read-only, port I) and the data requester (read/write, port D) of the multi-cycle CPU.
- Provides a req/ack handshake with a programmable number of memory wait states, so fetch and data states of the control unit stall until their access completes.
- Sits between the control unit/IR/data buffers and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, memory wait states (0..15) before m_rdata is valid.
- CNT_W, 4, wait counter width; must satisfy 2**CNT_W > WAIT_CYCLES.

Ports:
- CLK  in  1  clock; all flops rising-edge.
- RST  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  out  DATA_W  fetched word; registered.
- i_ack  out  1  one-cycle completion pulse for port I.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read word; registered.
- d_ack  out  1  one-cycle completion pulse for port D.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid after WAIT_CYCLES cycles of m_en.
- busy  out  1  high when the state is not IDLE.
- grant_d  out  1  1 = current or last grant went to port D.

Behaviour:
- Reset (RST low) takes effect immediately, mid-access included:
  - state = IDLE.
  - All outputs 0, including i_rdata, d_rdata and grant_d.
  - Counter = 0; any in-flight access is dropped with no ack.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req is sampled only in IDLE.
  - If any req is high, at the next edge: latch the winner's addr, we and wdata into the m_* registers, set m_en = 1, load counter = WAIT_CYCLES, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - m_* outputs are held stable.
  - The counter decrements each cycle.
  - When counter == 0, at that edge: for a read, capture m_rdata into the winner's rdata register; clear m_en and m_we; go to RESP.
- RESP:
  - Assert the winner's ack for exactly one cycle, then go to IDLE.
- Latency: req high at the edge ending IDLE → ack is high in cycle WAIT_CYCLES + 2 after it. Example: WAIT_CYCLES = 0 gives ack in the 2nd cycle.
- Requester rule: drop req in the cycle after ack unless a new access is intended. The minimum spacing between grants is therefore 3 + WAIT_CYCLES cycles.
- Writes: d_rdata is unchanged; m_wdata = d_wdata; m_we = 1 throughout ACCESS.
- Port I never drives m_we.
- Simultaneous requests in IDLE: port D wins (fixed priority). The loser keeps req high and is served on the next IDLE.
- The non-granted rdata register and ack are never disturbed.
- Protocol violation (req dropped during ACCESS): the access still completes and ack still pulses.
- rdata registers hold their value until the next read completion on the same port.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_RR_EN.
- Defined: round-robin on contention. A 1-bit last-winner flag (reset to I, so D wins the first tie) gives priority to the port not granted most recently.
- Not defined: fixed priority, D over I; no flag is implemented.
- A non-contended request is unaffected either way.

Decomposition:
- Package cpu_mem_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - requester id constants REQ_I = 0, REQ_D = 1;
  - default widths.
- One sub-module: mem_wait_counter.
  - Inputs: load, load value.
  - Behaviour: down-counter.
  - Output: done flag.
  - Instantiated once.

Test Plan:
- Reset mid-ACCESS (WAIT_CYCLES = 2, i_req, RST low on 2nd ACCESS cycle) → m_en drops asynchronously, no i_ack, busy = 0.
- Fetch only (WAIT_CYCLES = 1, i_addr = 0x0000_0004, m_rdata = 0x2001_0005) → i_ack one cycle, 3 cycles after the sampling edge; i_rdata = 0x2001_0005; m_we = 0 throughout.
- Data write then read (d_addr = 0x10, d_wdata = 0xDEAD_BEEF, then read 0x10 from a memory model) → m_we = 1 only during the write's ACCESS; d_rdata = 0xDEAD_BEEF after the read ack; i_rdata unchanged.
- i_req and d_req rise in the same cycle, macro off → D served first (grant_d = 1), I acked WAIT_CYCLES + 3 cycles later.
- Same contention repeated 4 times, UNIFIED_MEM_ARB_RR_EN defined → grant order D, I, D, I…, no starvation.
- WAIT_CYCLES = 0 back-to-back fetches with req held continuously → each ack exactly 3 cycles apart; no access is skipped or duplicated.
